// File: rtl/numeric_display_driver.sv
// numeric_display_driver: 4-digit multiplexed 7-segment scanner with PWM dimming
// and frame-synchronous double-buffered writes.
`default_nettype none

module numeric_display_driver #(
   parameter int unsigned C_SCAN_DIV     = 2500,
   parameter int unsigned C_BLANK_CYCLES = 16
) (
   input  logic        MCLK,
   input  logic        nRST,
   input  logic        EN,
   input  logic [3:0]  BRIGHT,
   input  logic        WR_EN,
   output logic        WR_READY,
   input  logic [15:0] WR_DATA,
   input  logic [3:0]  WR_DP,
   input  logic [1:0]  WR_COLON,
   output logic [13:0] KW4_56NCWB_P_Y_pins,
   output logic        FRAME_DONE
);

   localparam logic [13:0] PINS_OFF   = 14'h30FF;
   localparam logic [15:0] SLOT_LAST  = 16'(C_SCAN_DIV - 1);
   localparam logic [15:0] BLANK_LAST = 16'(C_BLANK_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_t;

   state_t      state;
   logic [15:0] slot_cnt;
   logic [1:0]  digit;
   logic [3:0]  pwm;
   logic        pending;
   logic [15:0] active_data, shadow_data;
   logic [3:0]  active_dp, shadow_dp;
   logic [1:0]  active_colon, shadow_colon;

   logic        slot_end, frame_end, accept, commit, lit;
   logic [3:0]  nibble;
   logic [6:0]  seg;
   logic [13:0] pins_next;

   assign slot_end  = (state == DRIVE) && (slot_cnt == SLOT_LAST);
   assign frame_end = slot_end && (digit == 2'd3);
   assign accept    = WR_EN && WR_READY;
   // Shadow only reaches the display between frames, or straight away while idle.
   assign commit    = pending && ((EN && frame_end) || (state == IDLE));
   assign lit       = EN && (state == DRIVE) && (pwm <= BRIGHT);

   always_comb begin
      nibble = active_data[3:0];
      case (digit)
         2'd0: nibble = active_data[3:0];
         2'd1: nibble = active_data[7:4];
         2'd2: nibble = active_data[11:8];
         2'd3: nibble = active_data[15:12];
         default: nibble = active_data[3:0];
      endcase
   end

   always_comb begin
      seg = 7'h00;
      case (nibble)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
         default: seg = 7'h00;
      endcase
   end

   always_comb begin
      pins_next = PINS_OFF;
      if (lit) begin
         pins_next = {~active_colon[1], ~active_colon[0], 4'b0001 << digit,
                      ~active_dp[digit], ~seg};
      end
   end

   always_ff @(posedge MCLK or negedge nRST) begin
      if (!nRST) begin
         state               <= IDLE;
         slot_cnt            <= 16'd0;
         digit               <= 2'd0;
         pwm                 <= 4'd0;
         pending             <= 1'b0;
         WR_READY            <= 1'b1;
         active_data         <= 16'd0;
         active_dp           <= 4'd0;
         active_colon        <= 2'd0;
         shadow_data         <= 16'd0;
         shadow_dp           <= 4'd0;
         shadow_colon        <= 2'd0;
         KW4_56NCWB_P_Y_pins <= PINS_OFF;
         FRAME_DONE          <= 1'b0;
      end else begin
         KW4_56NCWB_P_Y_pins <= pins_next;
         FRAME_DONE          <= EN && frame_end;

         if (accept) begin
            shadow_data  <= WR_DATA;
            shadow_dp    <= WR_DP;
            shadow_colon <= WR_COLON;
            pending      <= 1'b1;
            WR_READY     <= 1'b0;
         end
         if (commit) begin
            active_data  <= shadow_data;
            active_dp    <= shadow_dp;
            active_colon <= shadow_colon;
            pending      <= 1'b0;
            WR_READY     <= 1'b1;
         end

         if (!EN) begin
            state    <= IDLE;
            slot_cnt <= 16'd0;
            digit    <= 2'd0;
            pwm      <= 4'd0;
         end else begin
            case (state)
               IDLE: begin
                  state    <= BLANK;
                  slot_cnt <= 16'd0;
                  digit    <= 2'd0;
                  pwm      <= 4'd0;
               end
               BLANK: begin
                  slot_cnt <= slot_cnt + 16'd1;
                  if (slot_cnt == BLANK_LAST) begin
                     state <= DRIVE;
                     pwm   <= 4'd0;
                  end
               end
               DRIVE: begin
                  pwm <= pwm + 4'd1;
                  if (slot_end) begin
                     slot_cnt <= 16'd0;
                     digit    <= digit + 2'd1;
                     state    <= BLANK;
                  end else begin
                     slot_cnt <= slot_cnt + 16'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_numeric_display_driver.sv
// tb_numeric_display_driver: directed checks of scan timing, writes, PWM and reset.
`default_nettype none

module tb_numeric_display_driver;

   localparam logic [13:0] OFF = 14'h30FF;

   logic        MCLK = 1'b0;
   logic        nRST, EN, WR_EN;
   logic [3:0]  BRIGHT, WR_DP;
   logic [15:0] WR_DATA;
   logic [1:0]  WR_COLON;
   logic        WR_READY, WR_READY2, FRAME_DONE, FRAME_DONE2;
   logic [13:0] pins, pins2;
   int          total = 0;
   int          bad   = 0;

   always #5 MCLK = ~MCLK;

   numeric_display_driver #(.C_SCAN_DIV(8), .C_BLANK_CYCLES(2)) dut (
      .MCLK(MCLK), .nRST(nRST), .EN(EN), .BRIGHT(BRIGHT), .WR_EN(WR_EN),
      .WR_READY(WR_READY), .WR_DATA(WR_DATA), .WR_DP(WR_DP), .WR_COLON(WR_COLON),
      .KW4_56NCWB_P_Y_pins(pins), .FRAME_DONE(FRAME_DONE));

   numeric_display_driver #(.C_SCAN_DIV(40), .C_BLANK_CYCLES(4)) dut2 (
      .MCLK(MCLK), .nRST(nRST), .EN(EN), .BRIGHT(BRIGHT), .WR_EN(WR_EN),
      .WR_READY(WR_READY2), .WR_DATA(WR_DATA), .WR_DP(WR_DP), .WR_COLON(WR_COLON),
      .KW4_56NCWB_P_Y_pins(pins2), .FRAME_DONE(FRAME_DONE2));

   // Expected pins of the 8/2 instance at frame position p (p=0 is digit0's first blank cycle).
   function automatic logic [13:0] slot_pins(input int p, input logic [13:0] d0,
                                             input logic [13:0] d1, input logic [13:0] d2,
                                             input logic [13:0] d3);
      int q;
      logic [13:0] r;
      q = p % 32;
      if ((q % 8) < 2) r = OFF;
      else if (q < 8)  r = d0;
      else if (q < 16) r = d1;
      else if (q < 24) r = d2;
      else             r = d3;
      return r;
   endfunction

   task automatic test_reset();
      @(negedge MCLK);
      @(negedge MCLK);
      total++; if (pins !== OFF) begin bad++; $display("FAIL reset_pins got=%h exp=%h", pins, OFF); end
      total++; if (FRAME_DONE !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b exp=0", FRAME_DONE); end
      total++; if (WR_READY !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", WR_READY); end
      total++; if (pins2 !== OFF) begin bad++; $display("FAIL reset_pins2 got=%h exp=%h", pins2, OFF); end
      nRST = 1'b1;
      @(negedge MCLK);
      total++; if (pins !== OFF) begin bad++; $display("FAIL idle_pins got=%h exp=%h", pins, OFF); end
   endtask

   task automatic test_scan();
      logic e_fd;
      logic [13:0] e;
      WR_DATA = 16'h1234; WR_DP = 4'h0; WR_COLON = 2'b00; WR_EN = 1'b1;
      @(negedge MCLK);
      total++; if (WR_READY !== 1'b0) begin bad++; $display("FAIL scan_accept_ready got=%b exp=0", WR_READY); end
      WR_EN = 1'b0;
      @(negedge MCLK);
      total++; if (WR_READY !== 1'b1) begin bad++; $display("FAIL scan_idle_commit got=%b exp=1", WR_READY); end
      EN = 1'b1;
      @(negedge MCLK);
      total++; if (pins !== OFF) begin bad++; $display("FAIL scan_idle_cycle got=%h exp=%h", pins, OFF); end
      for (int p = 0; p < 64; p++) begin
         @(negedge MCLK);
         e    = slot_pins(p, 14'h3199, 14'h32B0, 14'h34A4, 14'h38F9);
         e_fd = ((p % 32) == 31);
         total++; if (pins !== e) begin bad++; $display("FAIL scan_pins p=%0d got=%h exp=%h", p, pins, e); end
         total++; if (FRAME_DONE !== e_fd) begin bad++; $display("FAIL scan_fd p=%0d got=%b exp=%b", p, FRAME_DONE, e_fd); end
      end
   endtask

   task automatic test_write();
      logic e_fd, e_rdy;
      logic [13:0] e;
      for (int p = 0; p < 64; p++) begin
         @(negedge MCLK);
         if (p < 32) e = slot_pins(p, 14'h3199, 14'h32B0, 14'h34A4, 14'h38F9);
         else        e = slot_pins(p, 14'h31A1, 14'h32C6, 14'h3483, 14'h3888);
         e_fd  = ((p % 32) == 31);
         e_rdy = !(p >= 10 && p <= 30);
         total++; if (pins !== e) begin bad++; $display("FAIL write_pins p=%0d got=%h exp=%h", p, pins, e); end
         total++; if (FRAME_DONE !== e_fd) begin bad++; $display("FAIL write_fd p=%0d got=%b exp=%b", p, FRAME_DONE, e_fd); end
         total++; if (WR_READY !== e_rdy) begin bad++; $display("FAIL write_ready p=%0d got=%b exp=%b", p, WR_READY, e_rdy); end
         case (p)
            9:  begin WR_EN = 1'b1; WR_DATA = 16'hABCD; end
            12: begin WR_EN = 1'b1; WR_DATA = 16'hFFFF; end
            default: WR_EN = 1'b0;
         endcase
      end
   endtask

   task automatic test_en_drop();
      logic e_fd, e_rdy;
      logic [13:0] e;
      for (int p = 0; p <= 20; p++) begin
         @(negedge MCLK);
         e     = slot_pins(p, 14'h31A1, 14'h32C6, 14'h3483, 14'h3888);
         e_rdy = (p < 19);
         total++; if (pins !== e) begin bad++; $display("FAIL drop_pins p=%0d got=%h exp=%h", p, pins, e); end
         total++; if (WR_READY !== e_rdy) begin bad++; $display("FAIL drop_ready p=%0d got=%b exp=%b", p, WR_READY, e_rdy); end
         WR_EN = (p == 18);
         if (p == 18) WR_DATA = 16'h1234;
         if (p == 20) EN = 1'b0;
      end
      for (int k = 0; k < 20; k++) begin
         @(negedge MCLK);
         e_rdy = (k >= 1);
         total++; if (pins !== OFF) begin bad++; $display("FAIL drop_off k=%0d got=%h exp=%h", k, pins, OFF); end
         total++; if (FRAME_DONE !== 1'b0) begin bad++; $display("FAIL drop_fd k=%0d got=%b exp=0", k, FRAME_DONE); end
         total++; if (WR_READY !== e_rdy) begin bad++; $display("FAIL drop_ready_idle k=%0d got=%b exp=%b", k, WR_READY, e_rdy); end
      end
      EN = 1'b1;
      @(negedge MCLK);
      total++; if (pins !== OFF) begin bad++; $display("FAIL drop_restart_idle got=%h exp=%h", pins, OFF); end
      for (int p = 0; p < 32; p++) begin
         @(negedge MCLK);
         e    = slot_pins(p, 14'h3199, 14'h32B0, 14'h34A4, 14'h38F9);
         e_fd = (p == 31);
         total++; if (pins !== e) begin bad++; $display("FAIL restart_pins p=%0d got=%h exp=%h", p, pins, e); end
         total++; if (FRAME_DONE !== e_fd) begin bad++; $display("FAIL restart_fd p=%0d got=%b exp=%b", p, FRAME_DONE, e_fd); end
      end
   endtask

   task automatic test_bright();
      int q, on_cnt;
      logic on;
      logic [3:0] e_dig;
      EN = 1'b0; BRIGHT = 4'd3;
      @(negedge MCLK);
      EN = 1'b1;
      @(negedge MCLK);
      on_cnt = 0;
      for (int i = 0; i < 160; i++) begin
         @(negedge MCLK);
         q     = i % 40;
         on    = (q >= 4) && (((q - 4) % 16) <= 3);
         e_dig = on ? (4'b0001 << (i / 40)) : 4'b0000;
         total++; if (pins2[11:8] !== e_dig) begin bad++; $display("FAIL pwm_digit i=%0d got=%h exp=%h", i, pins2[11:8], e_dig); end
         if (pins2[11:8] != 4'b0000) on_cnt++;
         if (q == 39) begin
            total++; if (on_cnt != 12) begin bad++; $display("FAIL pwm_on_count slot=%0d got=%0d exp=12", i / 40, on_cnt); end
            on_cnt = 0;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic e_fd;
      logic [13:0] e;
      EN = 1'b0; BRIGHT = 4'd15;
      @(negedge MCLK);
      EN = 1'b1;
      @(negedge MCLK);
      for (int i = 0; i < 4; i++) begin
         @(negedge MCLK);
         e = slot_pins(i, 14'h3199, 14'h32B0, 14'h34A4, 14'h38F9);
         total++; if (pins !== e) begin bad++; $display("FAIL rst_pre_pins i=%0d got=%h exp=%h", i, pins, e); end
      end
      WR_EN = 1'b1; WR_DATA = 16'h5555;
      @(negedge MCLK);
      WR_EN = 1'b0;
      total++; if (WR_READY !== 1'b0) begin bad++; $display("FAIL rst_pre_ready got=%b exp=0", WR_READY); end
      #2 nRST = 1'b0;
      #1;
      total++; if (pins !== OFF) begin bad++; $display("FAIL rst_async_pins got=%h exp=%h", pins, OFF); end
      total++; if (WR_READY !== 1'b1) begin bad++; $display("FAIL rst_async_ready got=%b exp=1", WR_READY); end
      total++; if (FRAME_DONE !== 1'b0) begin bad++; $display("FAIL rst_async_fd got=%b exp=0", FRAME_DONE); end
      @(negedge MCLK);
      @(negedge MCLK);
      total++; if (pins !== OFF) begin bad++; $display("FAIL rst_hold_pins got=%h exp=%h", pins, OFF); end
      nRST = 1'b1;
      @(negedge MCLK);
      total++; if (pins !== OFF) begin bad++; $display("FAIL rst_release_idle got=%h exp=%h", pins, OFF); end
      for (int p = 0; p < 64; p++) begin
         @(negedge MCLK);
         e    = slot_pins(p, 14'h31C0, 14'h32C0, 14'h34C0, 14'h38C0);
         e_fd = ((p % 32) == 31);
         total++; if (pins !== e) begin bad++; $display("FAIL rst_zero_pins p=%0d got=%h exp=%h", p, pins, e); end
         total++; if (FRAME_DONE !== e_fd) begin bad++; $display("FAIL rst_zero_fd p=%0d got=%b exp=%b", p, FRAME_DONE, e_fd); end
         total++; if (WR_READY !== 1'b1) begin bad++; $display("FAIL rst_zero_ready p=%0d got=%b exp=1", p, WR_READY); end
      end
   endtask

   task automatic test_dp_colon();
      logic [13:0] e;
      EN = 1'b0;
      WR_EN = 1'b1; WR_DATA = 16'h0000; WR_DP = 4'b0100; WR_COLON = 2'b10;
      @(negedge MCLK);
      WR_EN = 1'b0;
      @(negedge MCLK);
      total++; if (WR_READY !== 1'b1) begin bad++; $display("FAIL dp_commit_ready got=%b exp=1", WR_READY); end
      EN = 1'b1;
      @(negedge MCLK);
      for (int p = 0; p < 32; p++) begin
         @(negedge MCLK);
         e = slot_pins(p, 14'h11C0, 14'h12C0, 14'h1440, 14'h18C0);
         total++; if (pins !== e) begin bad++; $display("FAIL dp_pins p=%0d got=%h exp=%h", p, pins, e); end
      end
   endtask

   initial begin
      nRST = 1'b0; EN = 1'b0; BRIGHT = 4'd15; WR_EN = 1'b0;
      WR_DATA = 16'h0000; WR_DP = 4'h0; WR_COLON = 2'b00;
      test_reset();
      test_scan();
      test_write();
      test_en_drop();
      test_bright();
      test_reset_mid();
      test_dp_colon();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
